hv_stream_out: RTL and testbench

- Downstream of the bundling/sign-bit stage. Accepts each finished hypervector (one DIM+1-bit word per valid pulse) and buffers it in a small FIFO.
- Serialises each hypervector into DATA_W-bit AXI4-Stream beats for the output DMA.
- Counts hypervectors per job and asserts tlast on the final beat of the job.
- The upstream stage cannot stall, so overflow is flagged rather than back-pressured.

---
 rtl/hv_stream_out_pkg.sv | 19 +
 rtl/hv_stream_out_if.sv | 22 ++
 rtl/hv_stream_out_fifo.sv | 44 ++++
 rtl/hv_stream_out.sv | 125 ++++++++++++
 tb/tb_hv_stream_out.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hv_stream_out_pkg.sv
// Shared constants and types for the hypervector output streamer.
package hv_pkg;
  localparam int DIM    = 1023;
  localparam int DATA_W = 64;
  localparam int HV_W   = DIM + 1;
  // HV_W must be an exact multiple of DATA_W; the beat split relies on it.
  localparam int BEATS  = HV_W / DATA_W;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [DIM:0]                   hv_t;
  typedef logic [DATA_W-1:0]              beat_t;
  typedef logic [BIDX_W-1:0]              beat_idx_t;
  // Same bits as hv_t, viewed as BEATS words; word 0 is the low slice.
  typedef logic [BEATS-1:0][DATA_W-1:0]   hv_beats_t;

  typedef enum logic {IDLE, RUN} state_e;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);
endpackage

// File: rtl/hv_stream_out_if.sv
// Hypervector input and AXI4-Stream output of the streamer.
interface hv_stream_if import hv_pkg::*;;
  logic  in_valid;
  hv_t   in_data;
  logic  in_ready;
  beat_t m_axis_tdata;
  logic  m_axis_tvalid;
  logic  m_axis_tready;
  logic  m_axis_tlast;

  // Streamer side.
  modport slave (
    input  in_valid, in_data, m_axis_tready,
    output in_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  // Producer / sink side.
  modport master (
    output in_valid, in_data, m_axis_tready,
    input  in_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/hv_stream_out_fifo.sv
// Synchronous FIFO with combinational head. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module hv_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the addresses match.
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards all contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; when full with a pop, this slot is the one being vacated.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/hv_stream_out.sv
// Buffers finished hypervectors and serialises them into AXI4-Stream beats,
// low word first, with tlast on the final beat of each job.
module hv_stream_out import hv_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] hv_count,
  hv_stream_if.slave  io,
  output logic        busy,
  output logic        done,
  output logic        overflow
);
  state_e    state, state_nx;
  logic [31:0] hv_cnt, hv_idx;
  beat_idx_t beat_idx;

  beat_t     tdata_q;
  logic      tvalid_q, tlast_q;

  logic      fifo_full, fifo_empty;
  hv_t       fifo_head;
  hv_beats_t head_beats;

  logic      start_acc, hs, load, pop, push, ovf_evt, last_beat, job_end;

  assign head_beats = fifo_head;
  assign hs         = tvalid_q && io.m_axis_tready;
  assign last_beat  = (beat_idx == LAST_BEAT);

  // The upstream cannot stall: a full FIFO drops the word unless it pops now.
  assign push    = io.in_valid && (!fifo_full || pop);
  assign ovf_evt = io.in_valid && fifo_full && !pop;

  hv_fifo #(.W(HV_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (io.in_data),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state plus the load/pop decision for the output register.
  always_comb begin
    state_nx  = state;
    start_acc = 1'b0;
    load      = 1'b0;
    pop       = 1'b0;
    job_end   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          if (hv_count != 32'd0) state_nx = RUN;
        end
      end
      RUN: begin
        // Entries past hv_count stay queued for the next job.
        load = !fifo_empty && (hv_idx < hv_cnt) && (!tvalid_q || hs);
        pop  = load && last_beat;
        if (hs && tlast_q) begin
          job_end  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Job bookkeeping: counters, done pulse and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      hv_cnt   <= '0;
      hv_idx   <= '0;
      beat_idx <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (start_acc) begin
        hv_cnt   <= hv_count;
        hv_idx   <= '0;
        beat_idx <= '0;
      end else if (load) begin
        beat_idx <= last_beat ? '0 : beat_idx + beat_idx_t'(1);
        if (last_beat) hv_idx <= hv_idx + 32'd1;
      end
      done <= job_end || (start_acc && (hv_count == 32'd0));
      // A drop in the same cycle as start still counts for the new job.
      if (ovf_evt)        overflow <= 1'b1;
      else if (start_acc) overflow <= 1'b0;
    end
  end

  // Output register: holds stable while stalled, reloads on empty or handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else if (load) begin
      tdata_q  <= head_beats[beat_idx];
      tvalid_q <= 1'b1;
      tlast_q  <= last_beat && (hv_idx == hv_cnt - 32'd1);
    end else if (hs) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end
  end

  assign busy             = (state == RUN);
  assign io.in_ready      = !fifo_full;
  assign io.m_axis_tdata  = tdata_q;
  assign io.m_axis_tvalid = tvalid_q;
  assign io.m_axis_tlast  = tlast_q;
endmodule

// File: tb/tb_hv_stream_out.sv
// Directed bench for hv_stream_out.
module tb_hv_stream_out;
  import hv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] hv_count;
  logic        busy, done, overflow;

  int total = 0;
  int bad   = 0;

  beat_t exp_d[$];
  logic  exp_l[$];

  hv_stream_if io();

  hv_stream_out #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .hv_count (hv_count),
    .io       (io),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic hv_t make_hv(input int base);
    hv_t v;
    v = '0;
    for (int k = 0; k < BEATS; k++) v[k*DATA_W +: DATA_W] = beat_t'(base + k);
    return v;
  endfunction

  task automatic add_hv(input int base, input logic job_last);
    for (int k = 0; k < BEATS; k++) begin
      exp_d.push_back(beat_t'(base + k));
      exp_l.push_back(job_last && (k == BEATS - 1));
    end
  endtask

  task automatic write_hv(input int base);
    io.in_valid = 1'b1;
    io.in_data  = make_hv(base);
    tick();
    io.in_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] cnt);
    start    = 1'b1;
    hv_count = cnt;
    tick();
    start    = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Collect n handshaken beats against the expected queues.
  // mode 0: tready always high; mode 1: tready pattern 1,0,0 repeating.
  task automatic drain(input string tag, input int n, input int mode);
    int    got = 0;
    int    cyc = 0;
    logic  pend = 1'b0;
    beat_t pd = '0;
    logic  pl = 1'b0;
    beat_t ed;
    logic  el;
    while (got < n && cyc < 3000) begin
      if (pend) begin
        chk({tag, "_stall_valid"}, 64'(io.m_axis_tvalid), 64'(1));
        chk({tag, "_stall_data"}, io.m_axis_tdata, pd);
        chk({tag, "_stall_last"}, 64'(io.m_axis_tlast), 64'(pl));
      end
      io.m_axis_tready = (mode == 0) || (cyc % 3 == 0);
      if (io.m_axis_tvalid && io.m_axis_tready) begin
        ed = (exp_d.size() != 0) ? exp_d.pop_front() : 'x;
        el = (exp_l.size() != 0) ? exp_l.pop_front() : 1'bx;
        chk({tag, "_data"}, io.m_axis_tdata, ed);
        chk({tag, "_last"}, 64'(io.m_axis_tlast), 64'(el));
        got++;
      end
      pend = io.m_axis_tvalid && !io.m_axis_tready;
      pd   = io.m_axis_tdata;
      pl   = io.m_axis_tlast;
      tick();
      cyc++;
    end
    chk({tag, "_count"}, 64'(got), 64'(n));
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    start = 1'b0;
    hv_count = '0;
    io.in_valid = 1'b0;
    io.in_data = '0;
    io.m_axis_tready = 1'b0;
    tick();
    tick();
    // Reset state.
    chk("rst_tvalid", 64'(io.m_axis_tvalid), 64'(0));
    chk("rst_tdata", io.m_axis_tdata, 64'(0));
    chk("rst_tlast", 64'(io.m_axis_tlast), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_in_ready", 64'(io.in_ready), 64'(1));
    rst = 1'b0;
    tick();

    // Single hypervector, tready high.
    io.m_axis_tready = 1'b1;
    pulse_start(32'd1);
    chk("t1_busy", 64'(busy), 64'(1));
    write_hv(0);
    chk("t1_lat_not_yet", 64'(io.m_axis_tvalid), 64'(0));
    tick();
    chk("t1_lat_valid", 64'(io.m_axis_tvalid), 64'(1));
    chk("t1_lat_data", io.m_axis_tdata, 64'(0));
    add_hv(0, 1'b1);
    drain("t1", 16, 0);
    chk("t1_done", 64'(done), 64'(1));
    chk("t1_busy_end", 64'(busy), 64'(0));
    chk("t1_tvalid_end", 64'(io.m_axis_tvalid), 64'(0));
    tick();
    chk("t1_done_pulse", 64'(done), 64'(0));

    // Back-pressure with two hypervectors.
    io.m_axis_tready = 1'b0;
    pulse_start(32'd2);
    write_hv(100);
    write_hv(200);
    add_hv(100, 1'b0);
    add_hv(200, 1'b1);
    drain("t2", 32, 1);
    chk("t2_done", 64'(done), 64'(1));
    chk("t2_busy", 64'(busy), 64'(0));
    io.m_axis_tready = 1'b1;
    tick();
    tick();
    chk("t2_no_extra", 64'(io.m_axis_tvalid), 64'(0));

    // Overflow: five writes against a stalled four-deep FIFO.
    io.m_axis_tready = 1'b0;
    pulse_start(32'd5);
    write_hv(300);
    write_hv(400);
    write_hv(500);
    write_hv(600);
    chk("t3_full", 64'(io.in_ready), 64'(0));
    chk("t3_ovf_before", 64'(overflow), 64'(0));
    write_hv(700);
    chk("t3_ovf", 64'(overflow), 64'(1));
    add_hv(300, 1'b0);
    add_hv(400, 1'b0);
    add_hv(500, 1'b0);
    add_hv(600, 1'b0);
    drain("t3", 64, 0);
    chk("t3_no_done", 64'(done), 64'(0));
    chk("t3_still_busy", 64'(busy), 64'(1));
    tick();
    chk("t3_idle_bus", 64'(io.m_axis_tvalid), 64'(0));
    chk("t3_ovf_sticky", 64'(overflow), 64'(1));
    do_reset();
    chk("t3_ovf_rst", 64'(overflow), 64'(0));

    // Zero count.
    pulse_start(32'd0);
    chk("t4_done", 64'(done), 64'(1));
    chk("t4_busy", 64'(busy), 64'(0));
    chk("t4_tvalid", 64'(io.m_axis_tvalid), 64'(0));
    tick();
    chk("t4_done_pulse", 64'(done), 64'(0));
    chk("t4_busy2", 64'(busy), 64'(0));
    chk("t4_tvalid2", 64'(io.m_axis_tvalid), 64'(0));

    // Reset while beat 7 of the first hypervector is on the bus.
    io.m_axis_tready = 1'b1;
    pulse_start(32'd2);
    write_hv(800);
    write_hv(900);
    cyc = 0;
    while (!(io.m_axis_tvalid && io.m_axis_tdata == 64'd807) && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("t5_reach_beat7", io.m_axis_tdata, 64'd807);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_tvalid", 64'(io.m_axis_tvalid), 64'(0));
    chk("t5_tdata", io.m_axis_tdata, 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_ovf", 64'(overflow), 64'(0));
    pulse_start(32'd1);
    tick();
    tick();
    chk("t5_fifo_empty", 64'(io.m_axis_tvalid), 64'(0));
    write_hv(1000);
    add_hv(1000, 1'b1);
    drain("t5", 16, 0);
    chk("t5_done", 64'(done), 64'(1));

    // Full FIFO: push lands on the cycle beat 15 pops.
    io.m_axis_tready = 1'b0;
    pulse_start(32'd5);
    write_hv(1100);
    write_hv(1200);
    write_hv(1300);
    write_hv(1400);
    chk("t6_full", 64'(io.in_ready), 64'(0));
    chk("t6_beat0", io.m_axis_tdata, 64'd1100);
    io.m_axis_tready = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("t6_beat14", io.m_axis_tdata, 64'd1114);
    chk("t6_full_before", 64'(io.in_ready), 64'(0));
    write_hv(1500);
    chk("t6_ovf", 64'(overflow), 64'(0));
    chk("t6_still_full", 64'(io.in_ready), 64'(0));
    exp_d.push_back(64'd1115);
    exp_l.push_back(1'b0);
    add_hv(1200, 1'b0);
    add_hv(1300, 1'b0);
    add_hv(1400, 1'b0);
    add_hv(1500, 1'b1);
    drain("t6", 65, 0);
    chk("t6_done", 64'(done), 64'(1));
    chk("t6_ovf_end", 64'(overflow), 64'(0));
    chk("t6_empty", 64'(io.in_ready), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
